// File: rtl/imm_encoder_loader.sv
// Instruction encoder/loader: packs decoded fields plus immediate into a RISC-V word,
// checks immediate range, and writes the word to consecutive instruction-memory slots.
module imm_encoder_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RType,
  input  logic [1:0]        ImmSrc,
  input  logic [6:0]        Op,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [2:0]        Funct3,
  input  logic [6:0]        Funct7,
  input  logic [31:0]       Imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              range_err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, ENC, WR, ERR} state_t;

  typedef struct packed {
    logic        rtype;
    logic [1:0]  src;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fields_t;

  state_t              state_q, state_d;
  fields_t             fields_q, fields_d, fields_in;
  logic                ready_d, we_d, err_d, full_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         wdata_d;
  logic [CW-1:0]       count_d;
  logic [31:0]         enc_word;
  logic                enc_legal;
  logic                is_u;

  assign fields_in = '{rtype: RType, src: ImmSrc, op: Op, rd: Rd, rs1: Rs1, rs2: Rs2,
                       f3: Funct3, f7: Funct7, imm: Imm};

  assign is_u = (fields_q.op == 7'b0110111) || (fields_q.op == 7'b0010111);

  // Format-specific packing and range check of the latched bundle
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    if (fields_q.rtype) begin
      enc_word  = {fields_q.f7, fields_q.rs2, fields_q.rs1, fields_q.f3, fields_q.rd, fields_q.op};
      enc_legal = 1'b1;
    end else begin
      case (fields_q.src)
        2'b00: begin
          enc_word  = {fields_q.imm[11:0], fields_q.rs1, fields_q.f3, fields_q.rd, fields_q.op};
          enc_legal = (&fields_q.imm[31:11]) || !(|fields_q.imm[31:11]);
        end
        2'b01: begin
          enc_word  = {fields_q.imm[11:5], fields_q.rs2, fields_q.rs1, fields_q.f3,
                       fields_q.imm[4:0], fields_q.op};
          enc_legal = (&fields_q.imm[31:11]) || !(|fields_q.imm[31:11]);
        end
        2'b10: begin
          enc_word  = {fields_q.imm[12], fields_q.imm[10:5], fields_q.rs2, fields_q.rs1,
                       fields_q.f3, fields_q.imm[4:1], fields_q.imm[11], fields_q.op};
          enc_legal = ((&fields_q.imm[31:12]) || !(|fields_q.imm[31:12])) && !fields_q.imm[0];
        end
        default: begin
          if (is_u) begin
            enc_word  = {fields_q.imm[31:12], fields_q.rd, fields_q.op};
            enc_legal = !(|fields_q.imm[11:0]);
          end else begin
            enc_word  = {fields_q.imm[20], fields_q.imm[10:1], fields_q.imm[11],
                         fields_q.imm[19:12], fields_q.rd, fields_q.op};
            enc_legal = ((&fields_q.imm[31:20]) || !(|fields_q.imm[31:20])) && !fields_q.imm[0];
          end
        end
      endcase
    end
  end

  // Next state and next output values; clr overrides everything
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    we_d     = 1'b0;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    err_d    = range_err;
    full_d   = full;
    count_d  = count;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d  = ENC;
          fields_d = fields_in;
        end
      end
      ENC: begin
        if (enc_legal) begin
          state_d = WR;
          we_d    = 1'b1;
          wdata_d = enc_word;
        end else begin
          state_d = ERR;
        end
      end
      WR: begin
        state_d = IDLE;
        addr_d  = mem_addr + ADDR_W'(1);
        count_d = count + CW'(1);
        full_d  = (count_d == CAP);
      end
      ERR: begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      err_d   = 1'b0;
      full_d  = 1'b0;
      count_d = '0;
    end
    ready_d = (state_d == IDLE) && !full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fields_q  <= '0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      range_err <= 1'b0;
      full      <= 1'b0;
      count     <= '0;
    end else begin
      state_q   <= state_d;
      fields_q  <= fields_d;
      in_ready  <= ready_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      range_err <= err_d;
      full      <= full_d;
      count     <= count_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// Directed self-checking bench for imm_encoder_loader (4-word memory to reach full/wrap).
`timescale 1ns/1ps
module tb_imm_encoder_loader;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic          RType;
  logic [1:0]    ImmSrc;
  logic [6:0]    Op;
  logic [4:0]    Rd, Rs1, Rs2;
  logic [2:0]    Funct3;
  logic [6:0]    Funct7;
  logic [31:0]   Imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          range_err;
  logic          full;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  imm_encoder_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .RType(RType), .ImmSrc(ImmSrc), .Op(Op), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
    .Funct3(Funct3), .Funct7(Funct7), .Imm(Imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .range_err(range_err), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  // Core-style immediate extender: 0 I, 1 S, 2 B, 3 U, 4 J
  function automatic logic [31:0] ext(input logic [31:0] w, input int fmt);
    case (fmt)
      0: ext = {{20{w[31]}}, w[31:20]};
      1: ext = {{20{w[31]}}, w[31:25], w[11:7]};
      2: ext = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      3: ext = {w[31:12], 12'b0};
      default: ext = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // One handshake, then sample flags after each of the next four rising edges
  task automatic do_instr(input logic rt, input logic [1:0] src, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                          output logic [3:0] we_v, output logic [3:0] rdy_v,
                          output logic [3:0] err_v, output logic [31:0] wd,
                          output logic [AW-1:0] wa);
    @(negedge clk);
    RType = rt; ImmSrc = src; Op = op; Rd = rd; Rs1 = r1; Rs2 = r2;
    Funct3 = f3; Funct7 = f7; Imm = imm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; RType = ~rt; ImmSrc = ~src; Op = ~op; Rd = ~rd; Rs1 = ~r1; Rs2 = ~r2;
    Funct3 = ~f3; Funct7 = ~f7; Imm = ~imm;
    we_v = '0; rdy_v = '0; err_v = '0; wd = '0; wa = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      we_v[i] = mem_we; rdy_v[i] = in_ready; err_v[i] = range_err;
      if (mem_we) begin
        wd = mem_wdata;
        wa = mem_addr;
      end
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; RType = 1'b0; ImmSrc = '0; Op = '0;
    Rd = '0; Rs1 = '0; Rs2 = '0; Funct3 = '0; Funct7 = '0; Imm = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, range_err, full, count} !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%b we=%b addr=%0d err=%b full=%b cnt=%0d want 1 0 0 0 0 0",
               in_ready, mem_we, mem_addr, range_err, full, count);
    end
    checks++;
    if (mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_wdata: got %h want 00000000", mem_wdata);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, mem_we, count} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL reset_idle: got rdy=%b we=%b cnt=%0d want 1 0 0", in_ready, mem_we, count);
    end
  endtask

  task automatic test_itype();
    logic [3:0] we_v, rdy_v, err_v; logic [31:0] wd; logic [AW-1:0] wa;
    do_instr(1'b0, 2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if (we_v !== 4'b0001) begin errors++; $display("FAIL addi_we_timing: got %b want 0001", we_v); end
    checks++;
    if (wd !== 32'h00500093) begin errors++; $display("FAIL addi_word: got %h want 00500093", wd); end
    checks++;
    if (wa !== 2'd0) begin errors++; $display("FAIL addi_addr: got %0d want 0", wa); end
    checks++;
    if (rdy_v !== 4'b1110) begin errors++; $display("FAIL addi_ready: got %b want 1110", rdy_v); end
    checks++;
    if (count !== 3'd1) begin errors++; $display("FAIL addi_count: got %0d want 1", count); end
    checks++;
    if (ext(wd, 0) !== 32'd5) begin errors++; $display("FAIL addi_roundtrip: got %h want 00000005", ext(wd, 0)); end
  endtask

  task automatic test_store_branch();
    logic [3:0] we_v, rdy_v, err_v; logic [31:0] wd; logic [AW-1:0] wa;
    pulse_clr();
    do_instr(1'b0, 2'b01, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'hFFFFFFF8, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, wa, wd} !== {4'b0001, 2'd0, 32'hFE20AC23}) begin
      errors++; $display("FAIL sw: got we=%b addr=%0d word=%h want 0001 0 fe20ac23", we_v, wa, wd);
    end
    checks++;
    if (ext(wd, 1) !== 32'hFFFFFFF8) begin errors++; $display("FAIL sw_roundtrip: got %h want fffffff8", ext(wd, 1)); end
    do_instr(1'b0, 2'b10, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFFC, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, wa, wd} !== {4'b0001, 2'd1, 32'hFE208EE3}) begin
      errors++; $display("FAIL beq: got we=%b addr=%0d word=%h want 0001 1 fe208ee3", we_v, wa, wd);
    end
    checks++;
    if (ext(wd, 2) !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_roundtrip: got %h want fffffffc", ext(wd, 2)); end
    checks++;
    if (count !== 3'd2) begin errors++; $display("FAIL sb_count: got %0d want 2", count); end
  endtask

  task automatic test_uj_r();
    logic [3:0] we_v, rdy_v, err_v; logic [31:0] wd; logic [AW-1:0] wa;
    pulse_clr();
    do_instr(1'b0, 2'b11, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, wd} !== {4'b0001, 32'h123452B7}) begin
      errors++; $display("FAIL lui: got we=%b word=%h want 0001 123452b7", we_v, wd);
    end
    checks++;
    if (ext(wd, 3) !== 32'h12345000) begin errors++; $display("FAIL lui_roundtrip: got %h want 12345000", ext(wd, 3)); end
    do_instr(1'b0, 2'b11, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000800, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, wa, wd} !== {4'b0001, 2'd1, 32'h001000EF}) begin
      errors++; $display("FAIL jal: got we=%b addr=%0d word=%h want 0001 1 001000ef", we_v, wa, wd);
    end
    checks++;
    if (ext(wd, 4) !== 32'h00000800) begin errors++; $display("FAIL jal_roundtrip: got %h want 00000800", ext(wd, 4)); end
    // R-format ignores an immediate that would be illegal for B
    do_instr(1'b1, 2'b10, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'h00000003, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, err_v, wd} !== {4'b0001, 4'b0000, 32'h002081B3}) begin
      errors++; $display("FAIL rtype: got we=%b err=%b word=%h want 0001 0000 002081b3", we_v, err_v, wd);
    end
  endtask

  task automatic test_range_err();
    logic [3:0] we_v, rdy_v, err_v; logic [31:0] wd; logic [AW-1:0] wa;
    pulse_clr();
    do_instr(1'b0, 2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, err_v, rdy_v} !== {4'b0000, 4'b1110, 4'b1110}) begin
      errors++; $display("FAIL err_i: got we=%b err=%b rdy=%b want 0000 1110 1110", we_v, err_v, rdy_v);
    end
    do_instr(1'b0, 2'b10, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, err_v} !== {4'b0000, 4'b1111}) begin
      errors++; $display("FAIL err_b: got we=%b err=%b want 0000 1111", we_v, err_v);
    end
    do_instr(1'b0, 2'b11, 7'b0010111, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, err_v} !== {4'b0000, 4'b1111}) begin
      errors++; $display("FAIL err_u: got we=%b err=%b want 0000 1111", we_v, err_v);
    end
    checks++;
    if ({mem_addr, count} !== {2'd0, 3'd0}) begin
      errors++; $display("FAIL err_addr: got addr=%0d cnt=%0d want 0 0", mem_addr, count);
    end
    do_instr(1'b0, 2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, we_v, rdy_v, err_v, wd, wa);
    checks++;
    if ({we_v, wa, wd, err_v} !== {4'b0001, 2'd0, 32'h00500093, 4'b1111}) begin
      errors++; $display("FAIL err_then_legal: got we=%b addr=%0d word=%h err=%b want 0001 0 00500093 1111",
                         we_v, wa, wd, err_v);
    end
    pulse_clr();
    checks++;
    if (range_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", range_err); end
  endtask

  task automatic test_full();
    logic [3:0] we_v, rdy_v, err_v; logic [31:0] wd; logic [AW-1:0] wa;
    logic any_we, any_rdy;
    pulse_clr();
    for (int n = 0; n < 4; n++) begin
      do_instr(1'b0, 2'b00, 7'b0010011, 5'(n + 1), 5'd0, 5'd0, 3'b000, 7'd0, 32'(n), we_v, rdy_v, err_v, wd, wa);
      checks++;
      if ({we_v, wa} !== {4'b0001, 2'(n)}) begin
        errors++; $display("FAIL full_write%0d: got we=%b addr=%0d want 0001 %0d", n, we_v, wa, n);
      end
    end
    checks++;
    if (rdy_v !== 4'b0000) begin errors++; $display("FAIL full_ready_after4: got %b want 0000", rdy_v); end
    checks++;
    if ({full, in_ready, count, mem_addr} !== {1'b1, 1'b0, 3'd4, 2'd0}) begin
      errors++; $display("FAIL full_state: got full=%b rdy=%b cnt=%0d addr=%0d want 1 0 4 0",
                         full, in_ready, count, mem_addr);
    end
    @(negedge clk); in_valid = 1'b1; RType = 1'b0; ImmSrc = 2'b00; Imm = 32'd7;
    any_we = 1'b0; any_rdy = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      any_we = any_we | mem_we; any_rdy = any_rdy | in_ready;
    end
    in_valid = 1'b0;
    checks++;
    if ({any_we, any_rdy, count} !== {1'b0, 1'b0, 3'd4}) begin
      errors++; $display("FAIL full_holdoff: got we=%b rdy=%b cnt=%0d want 0 0 4", any_we, any_rdy, count);
    end
    pulse_clr();
    checks++;
    if ({full, in_ready, count, mem_addr} !== {1'b0, 1'b1, 3'd0, 2'd0}) begin
      errors++; $display("FAIL full_clr: got full=%b rdy=%b cnt=%0d addr=%0d want 0 1 0 0",
                         full, in_ready, count, mem_addr);
    end
  endtask

  task automatic test_abort();
    logic [3:0] we_v, rdy_v, err_v; logic [31:0] wd; logic [AW-1:0] wa;
    logic any_we;
    do_instr(1'b0, 2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, we_v, rdy_v, err_v, wd, wa);
    // clr during ENC drops the instruction and clears prior state
    @(negedge clk); Op = 7'b0010011; ImmSrc = 2'b00; RType = 1'b0; Imm = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    any_we = 1'b0;
    repeat (4) begin @(posedge clk); #1; any_we = any_we | mem_we; end
    checks++;
    if ({any_we, in_ready, mem_addr, mem_wdata, range_err, full, count} !==
        {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL clr_abort: got we=%b rdy=%b addr=%0d wd=%h err=%b full=%b cnt=%0d want 0 1 0 0 0 0 0",
                         any_we, in_ready, mem_addr, mem_wdata, range_err, full, count);
    end
    // clr beats in_valid in the same cycle
    @(negedge clk); in_valid = 1'b1; clr = 1'b1;
    @(negedge clk); in_valid = 1'b0; clr = 1'b0;
    any_we = 1'b0;
    repeat (4) begin @(posedge clk); #1; any_we = any_we | mem_we; end
    checks++;
    if ({any_we, count} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL clr_vs_valid: got we=%b cnt=%0d want 0 0", any_we, count);
    end
    // reset during WR drops the strobe immediately
    @(negedge clk); Imm = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_wr: got we=%b want 1", mem_we); end
    rst = 1'b0; #1;
    checks++;
    if ({mem_we, in_ready, mem_addr, mem_wdata, range_err, full, count} !==
        {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL rst_abort: got we=%b rdy=%b addr=%0d wd=%h err=%b full=%b cnt=%0d want 0 1 0 0 0 0 0",
                         mem_we, in_ready, mem_addr, mem_wdata, range_err, full, count);
    end
    @(negedge clk); rst = 1'b1;
    any_we = 1'b0;
    repeat (4) begin @(posedge clk); #1; any_we = any_we | mem_we; end
    checks++;
    if ({any_we, count} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL rst_no_write: got we=%b cnt=%0d want 0 0", any_we, count);
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_store_branch();
    test_uj_r();
    test_range_err();
    test_full();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
